crca_nrzi_rx: RTL

Serial receiver for the CRC-A link. It NRZI-decodes an incoming line, collects a fixed-length payload, and runs the trailing 16-bit CRC-A field through the same x^16 + x^12 + x^5 + 1 LFSR (init 0xC6C6). At end of frame it reports pass or fail. It sits at the far end of the serial CRC/NRZI path, opposite the CRC-A generator, and hands decoded payload to downstream logic.

---
 rtl/crca_nrzi_rx_if.sv | 26 ++
 rtl/crca_nrzi_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/crca_nrzi_rx_if.sv
// Serial CRC-A receiver bus: NRZI line input side and decoded payload/status side.
interface crca_nrzi_rx_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic                 enable_i;
  logic                 line_i;
  logic                 bit_valid_i;
  logic                 data_o;
  logic                 data_valid_o;
  logic [DATA_BITS-1:0] rx_data_o;
  logic [15:0]          rx_crc_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 crc_ok_o;
  logic                 crc_err_o;

  modport master (
    output enable_i, line_i, bit_valid_i,
    input  data_o, data_valid_o, rx_data_o, rx_crc_o, busy_o, done_o, crc_ok_o, crc_err_o
  );

  modport slave (
    input  enable_i, line_i, bit_valid_i,
    output data_o, data_valid_o, rx_data_o, rx_crc_o, busy_o, done_o, crc_ok_o, crc_err_o
  );
endinterface

// File: rtl/crca_nrzi_rx.sv
// NRZI-decoding CRC-A frame receiver: fixed-length payload followed by a 16-bit CRC,
// checked by running every bit through the x^16+x^12+x^5+1 LFSR and testing for zero residue.
module crca_nrzi_rx #(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  crca_nrzi_rx_if.slave  bus
);

  localparam int unsigned CNT_W    = ($clog2(DATA_BITS) < 4) ? 4 : $clog2(DATA_BITS);
  localparam logic [15:0] CRC_INIT = 16'hC6C6;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          r_q, r_d;
  logic                 prev_q, prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 data_q, data_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] rxd_q, rxd_d;
  logic [15:0]          rxc_q, rxc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;

  logic                 dec_bit_c;
  logic                 fb_c;
  logic [15:0]          r_step_c;

  // NRZI decode of the current sample and the LFSR advanced by that bit
  assign dec_bit_c = bus.line_i ^ prev_q;
  assign fb_c      = r_q[15] ^ dec_bit_c;
  assign r_step_c  = {r_q[14:0], 1'b0} ^ (fb_c ? CRC_POLY : 16'h0000);

  // State register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    rxd_d   = rxd_q;
    rxc_d   = rxc_q;
    ok_d    = ok_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          r_d     = CRC_INIT;
          prev_d  = bus.line_i;
          cnt_d   = CNT_W'(DATA_BITS - 1);
          rxd_d   = '0;
          rxc_d   = '0;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (bus.bit_valid_i) begin
          prev_d = bus.line_i;
          r_d    = r_step_c;
          rxd_d  = DATA_BITS'({rxd_q, dec_bit_c});
          data_d = dec_bit_c;
          dv_d   = 1'b1;
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(15);
            state_d = CRC;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      CRC: begin
        if (bus.bit_valid_i) begin
          prev_d = bus.line_i;
          r_d    = r_step_c;
          rxc_d  = {rxc_q[14:0], dec_bit_c};
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        ok_d    = (r_q == 16'h0000);
        err_d   = (r_q != 16'h0000);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags follow the state being entered so they line up with it
    busy_d = (state_d == PAYLOAD) || (state_d == CRC);
    done_d = (state_d == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_q    <= CRC_INIT;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      data_q <= 1'b0;
      dv_q   <= 1'b0;
      rxd_q  <= '0;
      rxc_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      rxd_q  <= rxd_d;
      rxc_q  <= rxc_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_valid_o = dv_q;
  assign bus.rx_data_o    = rxd_q;
  assign bus.rx_crc_o     = rxc_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.crc_ok_o     = ok_q;
  assign bus.crc_err_o    = err_q;

endmodule
